// File: rtl/mmcm_drp_reconfig.sv
// MMCME2_ADV CLKOUT1 divider retune over DRP: hold the MMCM in reset, read-modify-write
// ClkReg1/ClkReg2, release reset and wait for lock, with DRDY and lock timeouts.
module mmcm_drp_reconfig #(
    parameter logic [6:0] REG1_ADDR    = 7'h0A,
    parameter logic [6:0] REG2_ADDR    = 7'h0B,
    parameter int         RST_HOLD     = 16,
    parameter int         DRDY_TIMEOUT = 64,
    parameter int         LOCK_TIMEOUT = 65535
) (
    input  logic        board_clk_i,
    input  logic        RESETn_i,
    input  logic        req_i,
    input  logic [6:0]  div_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [6:0]  daddr_o,
    output logic        den_o,
    output logic        dwe_o,
    output logic [15:0] di_o,
    input  logic [15:0] do_i,
    input  logic        drdy_i,
    output logic        mmcm_rst_o,
    input  logic        locked_i
);

    // state | meaning
    // IDLE  | waiting for req_i; all DRP and reset outputs low
    // HOLD  | MMCM held in reset for RST_HOLD cycles before any DRP access
    // RD1   | one-cycle DRP read of ClkReg1
    // WT1   | waiting for read data of ClkReg1
    // WR1   | one-cycle DRP write of merged ClkReg1
    // WW1   | waiting for write acknowledge of ClkReg1
    // RD2   | one-cycle DRP read of ClkReg2
    // WT2   | waiting for read data of ClkReg2
    // WR2   | one-cycle DRP write of merged ClkReg2
    // WW2   | waiting for write acknowledge of ClkReg2
    // REL   | MMCM reset released; LOCKED still stale, ignored
    // LOCK  | waiting for locked_i or lock timeout
    typedef enum logic [3:0] {
        S_IDLE, S_HOLD,
        S_RD1, S_WT1, S_WR1, S_WW1,
        S_RD2, S_WT2, S_WR2, S_WW2,
        S_REL, S_LOCK
    } state_t;

    localparam int TMR_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT)
                           ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                           : ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    // The wait states are entered one cycle after the event they time from, hence -2.
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0] DRDY_LOAD = TMR_W'(DRDY_TIMEOUT - 2);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TIMEOUT - 2);

    localparam logic [15:0] REG1_KEEP = 16'hF000;
    localparam logic [15:0] REG2_KEEP = 16'hFF3F;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic [6:0]        div_q;
    logic [6:0]        div_nxt;
    logic [15:0]       rd_q;
    logic [15:0]       rd_nxt;
    logic              done_q;
    logic              done_nxt;
    logic              err_q;
    logic              err_nxt;

    logic              tmr_zero;
    logic              div_ok;
    logic              nocnt;
    logic              edge_bit;
    logic [5:0]        high;
    logic [5:0]        low;
    logic [15:0]       reg1_field;
    logic [15:0]       reg2_field;

    assign tmr_zero = (tmr == '0);
    assign div_ok   = (div_i != 7'd0) && (div_i != 7'd127);

    // Divide 1 is the no-count case: counters forced to 1/1 and edge cleared.
    always_comb begin
        nocnt    = (div_q == 7'd1);
        high     = nocnt ? 6'd1 : div_q[6:1];
        low      = nocnt ? 6'd1 : (div_q[5:0] - div_q[6:1]);
        edge_bit = div_q[0] & ~nocnt;
        reg1_field = {4'b0000, high, low};
        reg2_field = {8'h00, edge_bit, nocnt, 6'b000000};
    end

    always_ff @(posedge board_clk_i) begin
        if (!RESETn_i) begin
            state  <= S_IDLE;
            tmr    <= '0;
            div_q  <= '0;
            rd_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            div_q  <= div_nxt;
            rd_q   <= rd_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr_zero ? tmr : (tmr - TMR_W'(1));
        div_nxt   = div_q;
        rd_nxt    = rd_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_i) begin
                    if (div_ok) begin
                        div_nxt   = div_i;
                        tmr_nxt   = HOLD_LOAD;
                        state_nxt = S_HOLD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (tmr_zero) state_nxt = S_RD1;
            end
            S_RD1: begin
                tmr_nxt   = DRDY_LOAD;
                state_nxt = S_WT1;
            end
            S_WT1: begin
                if (drdy_i) begin
                    rd_nxt    = do_i;
                    state_nxt = S_WR1;
                end else if (tmr_zero) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WR1: begin
                tmr_nxt   = DRDY_LOAD;
                state_nxt = S_WW1;
            end
            S_WW1: begin
                if (drdy_i) begin
                    state_nxt = S_RD2;
                end else if (tmr_zero) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RD2: begin
                tmr_nxt   = DRDY_LOAD;
                state_nxt = S_WT2;
            end
            S_WT2: begin
                if (drdy_i) begin
                    rd_nxt    = do_i;
                    state_nxt = S_WR2;
                end else if (tmr_zero) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WR2: begin
                tmr_nxt   = DRDY_LOAD;
                state_nxt = S_WW2;
            end
            S_WW2: begin
                if (drdy_i) begin
                    state_nxt = S_REL;
                end else if (tmr_zero) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_REL: begin
                tmr_nxt   = LOCK_LOAD;
                state_nxt = S_LOCK;
            end
            S_LOCK: begin
                if (locked_i) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmr_zero) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state != S_IDLE);
        done_o     = done_q;
        err_o      = err_q;
        mmcm_rst_o = 1'b0;
        daddr_o    = 7'd0;
        den_o      = 1'b0;
        dwe_o      = 1'b0;
        di_o       = 16'h0000;
        unique case (state)
            S_HOLD: mmcm_rst_o = 1'b1;
            S_RD1: begin
                mmcm_rst_o = 1'b1;
                daddr_o    = REG1_ADDR;
                den_o      = 1'b1;
            end
            S_WT1, S_WW1: begin
                mmcm_rst_o = 1'b1;
                daddr_o    = REG1_ADDR;
            end
            S_WR1: begin
                mmcm_rst_o = 1'b1;
                daddr_o    = REG1_ADDR;
                den_o      = 1'b1;
                dwe_o      = 1'b1;
                di_o       = (rd_q & REG1_KEEP) | reg1_field;
            end
            S_RD2: begin
                mmcm_rst_o = 1'b1;
                daddr_o    = REG2_ADDR;
                den_o      = 1'b1;
            end
            S_WT2, S_WW2: begin
                mmcm_rst_o = 1'b1;
                daddr_o    = REG2_ADDR;
            end
            S_WR2: begin
                mmcm_rst_o = 1'b1;
                daddr_o    = REG2_ADDR;
                den_o      = 1'b1;
                dwe_o      = 1'b1;
                di_o       = (rd_q & REG2_KEEP) | reg2_field;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mmcm_drp_reconfig.md
# mmcm_drp_reconfig

Runtime reconfiguration controller for the MMCME2_ADV dynamic reconfiguration port (DRP), driving the DADDR/DEN/DWE/DI side and consuming DO/DRDY. On request it holds the MMCM in reset and read-modify-writes the CLKOUT1 divider registers. It then releases reset and waits for lock, letting software retune sysclk without a bitstream change. It sits beside the MMCM wrapper on the 100 MHz board clock, which also serves as DCLK.

## Interface
- REG1_ADDR, 7'h0A: DRP address of CLKOUT1 ClkReg1.
- REG2_ADDR, 7'h0B: DRP address of CLKOUT1 ClkReg2.
- RST_HOLD, 16: cycles mmcm_rst_o is held before the first DRP access (≥1).
- DRDY_TIMEOUT, 64: maximum cycles from den_o to drdy_i.
- LOCK_TIMEOUT, 65535: maximum cycles from reset release to locked_i.
- board_clk_i  in  1  DRP clock and block clock.
- RESETn_i  in  1  reset; one clock, synchronous, active-low.
- req_i  in  1  reconfigure request; sampled only in IDLE.
- div_i  in  7  new CLKOUT1 divide; valid range 1..126.
- busy_o  out  1  high while a reconfiguration is in progress.
- done_o  out  1  one-cycle pulse on success.
- err_o  out  1  one-cycle pulse on rejection or timeout.
- daddr_o  out  7  DRP address.
- den_o  out  1  DRP enable, one-cycle pulse.
- dwe_o  out  1  DRP write enable, high only with den_o.
- di_o  out  16  DRP write data.
- do_i  in  16  DRP read data, valid with drdy_i.
- drdy_i  in  1  DRP ready.
- mmcm_rst_o  out  1  MMCM reset request; external logic ORs it into RST.
- locked_i  in  1  MMCM LOCKED.

## Operation
- Reset values: all outputs 0; state IDLE.
- States: IDLE → HOLD → RD1 → WT1 → WR1 → WW1 → RD2 → WT2 → WR2 → WW2 → REL → LOCK → IDLE.
- IDLE, req_i=1, div_i in 1..126:
  - Latch div.
  - Enter HOLD.
  - busy_o and mmcm_rst_o rise the next cycle.
- IDLE, req_i=1, div_i=0 or 127:
  - err_o pulses the next cycle.
  - No DRP activity; busy_o stays 0.
- HOLD: count RST_HOLD cycles with mmcm_rst_o=1.
- RDn: issue one cycle with den_o=1, dwe_o=0, daddr_o=REGn_ADDR.
- WTn: wait for drdy_i; capture do_i.
- WRn: issue one cycle with den_o=1, dwe_o=1 and the same address; di_o = (captured & keep) | field.
- WWn: wait for drdy_i.
- Field arithmetic:
  - high = div>>1, low = div-high (6-bit each), edge = div[0], nocnt = (div==1).
  - Div 1: high=1, low=1.
- ClkReg1: keep mask 16'hF000; field = {4'b0, high, low}.
- ClkReg2: keep mask 16'hFF3F; field = edge<<7 | nocnt<<6.
- REL: drop mmcm_rst_o, then enter LOCK.
- LOCK:
  - Ignore locked_i in the first cycle after release.
  - Then on locked_i=1: pulse done_o, clear busy_o the same cycle, return to IDLE.
- Errors:
  - drdy_i not seen within DRDY_TIMEOUT of den_o: drop mmcm_rst_o, pulse err_o, go to IDLE.
  - locked_i not seen within LOCK_TIMEOUT: pulse err_o, go to IDLE.
- req_i while busy_o=1 is ignored; it is not queued.
- drdy_i outside WTn/WWn is ignored.
- RESETn_i low in any state: next edge returns to IDLE with all outputs 0, mmcm_rst_o included. A DRP write in flight is abandoned.

## Timing
- Request accepted at edge 0; mmcm_rst_o=1 from edge 1.
- First den_o at edge 1+RST_HOLD.
- With DRP latency d cycles (den_o to drdy_i), each access takes d+1 cycles. The next den_o follows drdy_i by one cycle.
- mmcm_rst_o falls one cycle after the second write's drdy_i.
- done_o rises L cycles after mmcm_rst_o falls, where L = lock time (L ≥ 2).
- No back-to-back DRP accesses; den_o is never high for two consecutive cycles.
- done_o and err_o are never high together.

## Test plan
- div=20, RST_HOLD=16, DRP model d=2 with reg1 do=16'hF0C3 and reg2 do=16'h00C5:
  - writes di=16'hF28A then 16'h0005.
  - den_o pulses at cycles 17, 20, 23, 26.
  - mmcm_rst_o falls at 29; done_o follows locked_i.
- div=7 → reg1 field 16'h00C4, reg2 bits[7:6]=2'b10.
- div=1 → reg1 field 16'h0041, reg2 bits[7:6]=2'b01.
- div=0 and div=127 → err_o pulse at cycle 1; den_o, busy_o and mmcm_rst_o stay 0.
- drdy_i withheld on the first read:
  - err_o pulses DRDY_TIMEOUT cycles after den_o.
  - mmcm_rst_o=0 and state IDLE.
  - A following valid req completes normally.
- RESETn_i asserted during WW1 → next edge: all outputs 0, IDLE. A req_i pulse while busy_o=1 produces no second sequence.
